// File: rtl/arb_pkg.sv
// Shared widths and state encoding for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority selector: first asserted req after 'last', with wrap.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // k = NUM_REQ wraps back to 'last' itself, so it is searched last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_4_rr.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module arbiter_4_rr
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 256)) begin : g_bad_max_hold
    $error("arbiter_4_rr: MAX_HOLD out of range 2..256");
  end

  state_t               state, state_nx;
  logic [NUM_REQ-1:0]   gnt_nx;
  logic [IDX_W-1:0]     idx_nx;
  logic                 valid_nx;
  logic                 timeout_nx;
  logic [IDX_W-1:0]     last, last_nx;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
`endif

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last      <= IDX_W'(NUM_REQ - 1);
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      timeout   <= timeout_nx;
      last      <= last_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_cnt_nx;
  end
`endif

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    idx_nx     = gnt_idx;
    valid_nx   = gnt_valid;
    last_nx    = last;
    timeout_nx = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_nx = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (!en && pick_any) begin
          state_nx = BUSY;
          gnt_nx   = NUM_REQ'(1) << pick_idx;
          idx_nx   = pick_idx;
          valid_nx = 1'b1;
          last_nx  = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_nx = '0;
`endif
        end
      end
      BUSY: begin
        // A voluntary release wins over a simultaneous limit hit.
        if (en || !req[gnt_idx]) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          idx_nx   = '0;
          valid_nx = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
          state_nx   = IDLE;
          gnt_nx     = '0;
          idx_nx     = '0;
          valid_nx   = 1'b0;
          timeout_nx = 1'b1;
        end else begin
          hold_cnt_nx = hold_cnt + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        idx_nx   = '0;
        valid_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arbiter_4_rr.sv
// Directed self-checking bench for arbiter_4_rr (MAX_HOLD=4).
module tb_arbiter_4_rr;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  arbiter_4_rr #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                     input logic et);
    logic ev;
    ev = (eg != 4'b0000);
    n_cmp++;
    assert ({gnt, gnt_idx, gnt_valid, timeout} === {eg, ei, ev, et})
    else begin
      n_err++;
      $error("FAIL %s: observed gnt=%b idx=%0d valid=%b timeout=%b, expected gnt=%b idx=%0d valid=%b timeout=%b",
             tag, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
    end
    n_cmp++;
    assert ($countones(gnt) <= 1)
    else begin
      n_err++;
      $error("FAIL %s_onehot: observed gnt=%b, expected at most one bit", tag, gnt);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    step(); step();
    chk("reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;

    // basic grant / release
    req = 4'b0001; step(); chk("grant0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000; step(); chk("release0", 4'b0000, 2'd0, 1'b0);
    step(); chk("idle_noreq", 4'b0000, 2'd0, 1'b0);

    // rotation from reset with all requesting
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; step(); chk("rot0", 4'b0001, 2'd0, 1'b0);
    step(); chk("hold0_a", 4'b0001, 2'd0, 1'b0);
    step(); chk("hold0_b", 4'b0001, 2'd0, 1'b0);
    req = 4'b1110; step(); chk("rot_gap0", 4'b0000, 2'd0, 1'b0);
    req = 4'b1111; step(); chk("rot1", 4'b0010, 2'd1, 1'b0);
    req = 4'b1101; step(); chk("rot_gap1", 4'b0000, 2'd0, 1'b0);
    req = 4'b1111; step(); chk("rot2", 4'b0100, 2'd2, 1'b0);
    req = 4'b1011; step(); chk("rot_gap2", 4'b0000, 2'd0, 1'b0);
    req = 4'b1111; step(); chk("rot3", 4'b1000, 2'd3, 1'b0);
    req = 4'b0111; step(); chk("rot_gap3", 4'b0000, 2'd0, 1'b0);
    req = 4'b1111; step(); chk("rot_wrap", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000; step(); chk("rot_end", 4'b0000, 2'd0, 1'b0);

    // last=1, req=1001 must go to 3
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0010; step(); chk("last1_grant", 4'b0010, 2'd1, 1'b0);
    req = 4'b0000; step(); chk("last1_rel", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001; step(); chk("prio_after1", 4'b1000, 2'd3, 1'b0);
    req = 4'b0000; step(); chk("prio_rel", 4'b0000, 2'd0, 1'b0);

    // single persistent requester gets repeat grants with an idle gap
    req = 4'b0001; step(); chk("persist_g1", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000; step(); chk("persist_gap", 4'b0000, 2'd0, 1'b0);
    req = 4'b0001; step(); chk("persist_g2", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000; step(); chk("persist_end", 4'b0000, 2'd0, 1'b0);

    // enable revoke on idx 2, then regrant
    req = 4'b0100; step(); chk("en_grant2", 4'b0100, 2'd2, 1'b0);
    en = 1'b1; step(); chk("en_revoke", 4'b0000, 2'd0, 1'b0);
    step(); chk("en_blocked", 4'b0000, 2'd0, 1'b0);
    en = 1'b0; step(); chk("en_regrant", 4'b0100, 2'd2, 1'b0);

    // reset mid-grant, then priority restarts at 0
    rst = 1'b1; step(); chk("rst_mid", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0; req = 4'b1111; step(); chk("rst_regrant", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000; step(); chk("rst_rel", 4'b0000, 2'd0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0011; step(); chk("to_h1", 4'b0001, 2'd0, 1'b0);
    step(); chk("to_h2", 4'b0001, 2'd0, 1'b0);
    step(); chk("to_h3", 4'b0001, 2'd0, 1'b0);
    step(); chk("to_h4", 4'b0001, 2'd0, 1'b0);
    step(); chk("to_pulse", 4'b0000, 2'd0, 1'b1);
    step(); chk("to_next", 4'b0010, 2'd1, 1'b0);
    step(); step(); step(); chk("to_h4b", 4'b0010, 2'd1, 1'b0);
    req = 4'b0001; step(); chk("to_voluntary", 4'b0000, 2'd0, 1'b0);
    req = 4'b0000; step(); chk("to_idle", 4'b0000, 2'd0, 1'b0);
`else
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0011; step(); chk("nto_g", 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk("nto_hold", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000; step(); chk("nto_rel", 4'b0000, 2'd0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arbiter_4_rr.md
ARBITER_4_RR -- requirements
Module: arbiter_4_rr

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum cycles one requester may hold the grant (used only with ARB_TIMEOUT_EN; legal range 2..256).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  active-low arbiter enable; 0 = arbitrate, 1 = no grants.
REQ-005 req  input  4  request lines, req[i] held high by requester i until finished.
REQ-006 gnt  output  4  registered one-hot grant; at most one bit high.
REQ-007 gnt_idx  output  2  registered binary index of current owner; 0 when no grant.
REQ-008 gnt_valid  output  1  registered; high exactly when gnt != 0.
REQ-009 timeout  output  1  registered one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Function
REQ-010 Two states, IDLE and BUSY; gnt, gnt_idx, gnt_valid are registered outputs.
REQ-011 IDLE, en=0, req!=0: pick first i with req[i]=1, searching from (last+1) mod 4 upward with wrap (3->0); next edge: BUSY, gnt=one-hot(i), gnt_idx=i, gnt_valid=1, last=i.
REQ-012 Grant latency: exactly one cycle from req sampled high in IDLE to gnt high.
REQ-013 IDLE with req=0 or en=1: remain IDLE, outputs 0.
REQ-014 BUSY: while req[gnt_idx]=1 and en=0 (and no timeout), hold grant unchanged; changes on other req bits ignored.
REQ-015 BUSY with req[gnt_idx]=0: next edge IDLE, gnt=0, gnt_idx=0, gnt_valid=0; no grant in that same edge (minimum one idle cycle between grants).
REQ-016 BUSY with en=1: revoke grant on next edge exactly as REQ-015; last unchanged.
REQ-017 Single persistent requester i receives repeat grants, each separated by one idle cycle.
REQ-018 All four requesting continuously: grant order rotates 0,1,2,3,0,... from reset.
REQ-019 gnt shall never have more than one bit set, in any cycle.

Reset
REQ-020 rst=1 at an edge: state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, hold counter=0, last=3 (so req[0] has top priority first).
REQ-021 rst asserted mid-grant revokes the grant at that edge; rst overrides all other inputs.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: hold counter clears on grant, increments each BUSY cycle; when owner has held for MAX_HOLD cycles, next edge forces release per REQ-015 and pulses timeout=1 for one cycle.
REQ-023 Owner releasing (req drop) in the same cycle the limit is reached: normal release, timeout stays 0.
REQ-024 Macro undefined: no counter logic, grants held indefinitely, timeout tied 0; MAX_HOLD ignored.

Structure
REQ-025 Package arb_pkg holds: NUM_REQ=4, IDX_W=2, state typedef (IDLE, BUSY).
REQ-026 Sub-module rr_pick4: combinational rotating-priority selector, inputs req[3:0], last[1:0], outputs idx[1:0], any; arbiter_4_rr instantiates it once.

Verification
REQ-027 Reset, req=0001 -> gnt=0001, gnt_idx=0, gnt_valid=1 one cycle later; drop req[0] -> gnt=0000 next cycle.
REQ-028 req=1111 held -> grants 0001,0010,0100,1000,0001 with one zero cycle between each.
REQ-029 last=1, req=1001 -> gnt=1000 (idx 3), not 0001.
REQ-030 Grant to idx 2 active, en=1 -> gnt=0000 next cycle; en back 0 with req=0100 -> gnt=0100 after one idle cycle.
REQ-031 ARB_TIMEOUT_EN, MAX_HOLD=4, req=0011 held -> gnt=0001 for 4 cycles, timeout pulse, idle cycle, then gnt=0010.
REQ-032 rst pulsed while gnt=0100 -> next edge all outputs 0; following grant with req=1111 goes to idx 0.
